stopwatch_top: RTL and testbench
================================

STOPWATCH_TOP -- requirements
Module: stopwatch_top

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 1, number of clk cycles per counted second (legal range 1 to 2^27).
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-low.
REQ-004 Port: start  input  1  start/resume request, sampled each rising edge.
REQ-005 Port: pause  input  1  pause request, sampled each rising edge.
REQ-006 Port: sec  output  6  seconds count, 0-59, registered.
REQ-007 Port: min  output  6  minutes count, 0-59, registered.

Function
REQ-008 Control FSM states: IDLE (after reset, never run), RUN, PAUSED.
REQ-009 IDLE or PAUSED with start=1 and pause=0 at an edge SHALL go to RUN.
REQ-010 RUN with pause=1 at an edge SHALL go to PAUSED.
REQ-011 Start and pause both high at an edge: pause wins; the FSM never enters RUN on that edge, and leaves RUN if it was in RUN.
REQ-012 Start while in RUN and pause while in IDLE or PAUSED SHALL have no effect.
REQ-013 Inputs are level-sampled, and a multi-cycle pulse acts identically to a single-cycle pulse.
REQ-014 Prescaler: counter 0..TICKS_PER_SEC-1.
  - It advances only on edges where the state is RUN and pause=0.
  - A tick is asserted on the advancing edge where it holds TICKS_PER_SEC-1; the prescaler then wraps to 0.
REQ-015 Prescaler holds its value while IDLE or PAUSED, so resume continues the partial second.
REQ-016 On a tick, sec increments by 1.
  - sec=59 wraps to 0 and min increments by 1 on the same edge.
REQ-017 Wrap behaviour at 59:59 is set by REQ-024/025.
REQ-018 Timing with TICKS_PER_SEC=1:
  - The edge that samples start does not count.
  - Each following RUN edge with pause=0 increments sec once.
  - The edge that samples pause does not count.
REQ-019 sec and min SHALL never hold a value above 59.

Reset
REQ-020 rst=0 at a rising edge sets sec=0, min=0, prescaler=0 and state=IDLE, overriding start and pause.
REQ-021 Reset mid-count (RUN or PAUSED) takes effect on that edge; after rst returns high, counting restarts only after a new start.
REQ-022 Outputs SHALL be 0 from the first edge with rst=0 and remain 0 while rst=0.

Configuration
REQ-023 Macro STOPWATCH_SATURATE_EN selects behaviour at 59:59.
REQ-024 Without STOPWATCH_SATURATE_EN: a tick at 59:59 SHALL wrap to 00:00 and counting continues.
REQ-025 With STOPWATCH_SATURATE_EN: a tick at 59:59 SHALL leave 59:59 unchanged and the FSM goes to PAUSED; start then has no effect until reset.

Structure
REQ-026 Package stopwatch_pkg SHALL hold:
  - the FSM state enum type (IDLE, RUN, PAUSED);
  - constant MAX_SEC=59;
  - constant MAX_MIN=59;
  - the 6-bit count typedef.
REQ-027 Sub-module stopwatch_prescaler SHALL hold the TICKS_PER_SEC counter and emit a one-cycle tick.
  - Inputs: clk, rst, enable.
  - Output: tick.
REQ-028 The FSM and the sec/min counters reside in stopwatch_top.

Verification (TICKS_PER_SEC=1 unless stated)
REQ-029 Reset then idle: rst=0 for 2 cycles, release, 10 cycles with no start -> sec=0, min=0 throughout.
REQ-030 Count and minute rollover: 1-cycle start, then 65 cycles -> min=1, sec=5; check the edge where sec goes 59->0 and min goes 0->1.
REQ-031 Pause and resume:
  - From 01:05, 1-cycle pause then 15 idle cycles -> held at 01:05.
  - 1-cycle start then 10 cycles -> 01:15.
REQ-032 Conflicts and redundant requests:
  - start and pause high together from IDLE -> stays 00:00.
  - start pulse while RUN -> count unaffected.
REQ-033 Mid-run reset: 1-cycle rst=0 while RUN at 01:15 -> 00:00 next edge; remains 00:00 for 5 cycles without start.
REQ-034 59:59 boundary:
  - Run 3600 ticks -> 00:00 without the macro; 59:59 held with STOPWATCH_SATURATE_EN.
  - With TICKS_PER_SEC=4: sec increments every 4th RUN cycle, and the partial count is retained across pause.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch: FSM state encoding and the 6-bit count type.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int unsigned COUNT_W = 6;
  localparam int unsigned MAX_SEC = 59;
  localparam int unsigned MAX_MIN = 59;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/stopwatch_prescaler.sv
// Divides clk down to one tick per counted second; holds its partial count when disabled.
module stopwatch_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Tick fires on the same edge the counter wraps so the top can count on it directly.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/stopwatch_top.sv
// Stopwatch with start/pause control and mm:ss counters.
// Define STOPWATCH_SATURATE_EN to hold at 59:59 and lock out start until reset; otherwise wraps to 00:00.
module stopwatch_top
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   pause,
  output count_t sec,
  output count_t min
);

  state_t state;
  state_t state_next;
  logic   enable;
  logic   tick;
  logic   advance;
  logic   can_start;

  stopwatch_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

`ifdef STOPWATCH_SATURATE_EN
  logic locked;
  logic lock_next;
  logic at_max;

  assign at_max    = (sec == COUNT_W'(MAX_SEC)) && (min == COUNT_W'(MAX_MIN));
  assign advance   = tick && !at_max;
  assign can_start = !locked;

  always_ff @(posedge clk) begin
    if (!rst) begin
      locked <= 1'b0;
    end else begin
      locked <= lock_next;
    end
  end
`else
  assign advance   = tick;
  assign can_start = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; pause always dominates start
  always_comb begin
    state_next = state;
`ifdef STOPWATCH_SATURATE_EN
    lock_next  = locked;
`endif
    case (state)
      IDLE, PAUSED: begin
        if (start && !pause && can_start) state_next = RUN;
      end
      RUN: begin
        if (pause) begin
          state_next = PAUSED;
        end
`ifdef STOPWATCH_SATURATE_EN
        else if (tick && at_max) begin
          state_next = PAUSED;
          lock_next  = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the prescaler only advances on RUN edges without a pause request
  always_comb begin
    enable = 1'b0;
    if (state == RUN && !pause) enable = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sec <= '0;
      min <= '0;
    end else if (advance) begin
      if (sec == COUNT_W'(MAX_SEC)) begin
        sec <= '0;
        min <= (min == COUNT_W'(MAX_MIN)) ? '0 : min + COUNT_W'(1);
      end else begin
        sec <= sec + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_top.sv
// Directed bench for stopwatch_top: one instance at 1 tick/s, one at 4 ticks/s.
module tb_stopwatch_top;
  import stopwatch_pkg::*;

  logic   clk = 1'b0;
  logic   rst, start, pause;
  logic   rst4, start4, pause4;
  count_t sec, min, sec4, min4;
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  stopwatch_top #(.TICKS_PER_SEC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .sec(sec), .min(min)
  );

  stopwatch_top #(.TICKS_PER_SEC(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .pause(pause4), .sec(sec4), .min(min4)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int m, input int s);
    check({tag, ".min"}, int'(min), m);
    check({tag, ".sec"}, int'(sec), s);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    rst4 = 1'b0; start4 = 1'b0; pause4 = 1'b0;

    // Reset then idle
    step(2);
    check_time("reset", 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_time("idle", 0, 0);
    end

    // Start edge does not count; 65 counting edges follow
    start = 1'b1; step(1); start = 1'b0;
    check_time("start_edge", 0, 0);
    step(59);
    check_time("pre_roll", 0, 59);
    step(1);
    check_time("roll", 1, 0);
    step(5);
    check_time("run65", 1, 5);

    // Pause and resume
    pause = 1'b1; step(1); pause = 1'b0;
    step(15);
    check_time("paused", 1, 5);
    start = 1'b1; step(1); start = 1'b0;
    check_time("resume_edge", 1, 5);
    step(10);
    check_time("resumed", 1, 15);

    // Mid-run reset
    rst = 1'b0; step(1); rst = 1'b1;
    check_time("midrst", 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_time("post_rst", 0, 0);
    end

    // Start and pause together from IDLE: pause wins
    start = 1'b1; pause = 1'b1; step(1); start = 1'b0; pause = 1'b0;
    step(3);
    check_time("conflict_idle", 0, 0);

    // Redundant start while running (multi-cycle) leaves counting unaffected
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    check_time("run3", 0, 3);
    start = 1'b1; step(2); start = 1'b0;
    check_time("start_in_run", 0, 5);
    step(1);
    check_time("after_start_in_run", 0, 6);

    // Start and pause together while running: leaves RUN; long pause same as short
    start = 1'b1; pause = 1'b1; step(1); start = 1'b0;
    step(2); pause = 1'b0;
    step(3);
    check_time("conflict_run", 0, 6);
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    check_time("resume2", 0, 8);

    // 59:59 boundary
    rst = 1'b0; step(1); rst = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    step(3599);
    check_time("at_max", 59, 59);
    step(1);
`ifdef STOPWATCH_SATURATE_EN
    check_time("sat_hold", 59, 59);
    step(2);
    check_time("sat_hold2", 59, 59);
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    check_time("sat_locked", 59, 59);
`else
    check_time("wrap", 0, 0);
    step(2);
    check_time("wrap_continue", 0, 2);
`endif

    // TICKS_PER_SEC=4: every 4th RUN edge counts, partial second kept across pause
    rst4 = 1'b0; step(1); rst4 = 1'b1;
    check("t4.reset", int'(sec4), 0);
    start4 = 1'b1; step(1); start4 = 1'b0;
    step(3);
    check("t4.3edges", int'(sec4), 0);
    step(1);
    check("t4.4edges", int'(sec4), 1);
    step(2);
    pause4 = 1'b1; step(1); pause4 = 1'b0;
    step(5);
    check("t4.paused", int'(sec4), 1);
    start4 = 1'b1; step(1); start4 = 1'b0;
    step(1);
    check("t4.partial", int'(sec4), 1);
    step(1);
    check("t4.retained", int'(sec4), 2);
    check("t4.min", int'(min4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
